// File: rtl/sobel_stream_filter_if.sv
// Camera pixel stream in, Sobel result stream out.
// master: camera / sink side, slave: the filter.
interface sobel_stream_filter_if #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned COL_WIDTH   = 10,
  parameter int unsigned ROW_WIDTH   = 9
);
  logic                   hsync;
  logic                   vsync;
  logic                   validCamera;
  logic [PIXEL_WIDTH-1:0] camData;

  logic                   pixelValid;
  logic [PIXEL_WIDTH+2:0] magnitude;
  logic [COL_WIDTH-1:0]   pixelX;
  logic [ROW_WIDTH-1:0]   pixelY;
  logic                   edgeOut;
  logic                   lineOverflow;

  modport master (
    output hsync, vsync, validCamera, camData,
    input  pixelValid, magnitude, pixelX, pixelY, edgeOut, lineOverflow
  );

  modport slave (
    input  hsync, vsync, validCamera, camData,
    output pixelValid, magnitude, pixelX, pixelY, edgeOut, lineOverflow
  );
endinterface

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge detector: two circular line buffers, a 3x3
// window and a fixed 3-stage pipeline producing |Gx|+|Gy| per interior pixel.
// Optional threshold output enabled by defining SOBEL_THRESHOLD_EN.
module sobel_stream_filter #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned LINE_WIDTH  = 640,
  parameter int unsigned COL_WIDTH   = 10,
  parameter int unsigned ROW_WIDTH   = 9
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH+2:0] threshold,
  sobel_stream_filter_if.slave   bus
);
  localparam int unsigned MAG_WIDTH  = PIXEL_WIDTH + 3;
  localparam int unsigned GRAD_WIDTH = PIXEL_WIDTH + 4;
  localparam int unsigned ADDR_WIDTH = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  logic                   accept;
  logic                   overflowHit;
  logic                   shiftEn;
  logic                   hsyncRise;
  logic                   eligible;
  logic                   hsyncPrev;
  logic [COL_WIDTH-1:0]   colCount;
  logic [ROW_WIDTH-1:0]   rowCount;
  logic [ADDR_WIDTH-1:0]  lbAddr;
  logic [PIXEL_WIDTH-1:0] lineBuf0 [LINE_WIDTH];
  logic [PIXEL_WIDTH-1:0] lineBuf1 [LINE_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb0Rd;
  logic [PIXEL_WIDTH-1:0] lb1Rd;
  logic [PIXEL_WIDTH-1:0] win [3][3];

  logic                   s1Valid;
  logic [COL_WIDTH-1:0]   s1X;
  logic [ROW_WIDTH-1:0]   s1Y;

  logic signed [GRAD_WIDTH-1:0] gxSum;
  logic signed [GRAD_WIDTH-1:0] gySum;
  logic signed [GRAD_WIDTH-1:0] gxReg;
  logic signed [GRAD_WIDTH-1:0] gyReg;
  logic                         s2Valid;
  logic [COL_WIDTH-1:0]         s2X;
  logic [ROW_WIDTH-1:0]         s2Y;

  logic [MAG_WIDTH-1:0]   magSum;
  logic                   edgeNext;
  logic                   pixelValidReg;
  logic [MAG_WIDTH-1:0]   magnitudeReg;
  logic [COL_WIDTH-1:0]   pixelXReg;
  logic [ROW_WIDTH-1:0]   pixelYReg;
  logic                   edgeReg;
  logic                   lineOverflowReg;

  function automatic logic signed [GRAD_WIDTH-1:0] ext(input logic [PIXEL_WIDTH-1:0] p);
    return $signed(GRAD_WIDTH'(p));
  endfunction

  function automatic logic [MAG_WIDTH-1:0] absMag(input logic signed [GRAD_WIDTH-1:0] v);
    logic [GRAD_WIDTH-1:0] a;
    a = v[GRAD_WIDTH-1] ? GRAD_WIDTH'(-v) : GRAD_WIDTH'(v);
    return MAG_WIDTH'(a);
  endfunction

  // Accept qualification; the column counter parks at LINE_WIDTH once a line overflows.
  assign accept      = bus.validCamera & ~bus.hsync & ~bus.vsync;
  assign overflowHit = accept && ({1'b0, colCount} == (COL_WIDTH + 1)'(LINE_WIDTH));
  assign shiftEn     = accept & ~overflowHit;
  assign hsyncRise   = bus.hsync & ~hsyncPrev;
  assign eligible    = shiftEn && (colCount >= COL_WIDTH'(2)) && (rowCount >= ROW_WIDTH'(2));
  assign lbAddr      = ADDR_WIDTH'(colCount);
  assign lb0Rd       = lineBuf0[lbAddr];
  assign lb1Rd       = lineBuf1[lbAddr];

  // Column/row counters, hsync edge detect and sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsyncPrev       <= 1'b0;
      colCount        <= '0;
      rowCount        <= '0;
      lineOverflowReg <= 1'b0;
    end else begin
      hsyncPrev <= bus.hsync;
      if (bus.vsync) begin
        colCount        <= '0;
        rowCount        <= '0;
        lineOverflowReg <= 1'b0;
      end else begin
        if (bus.hsync) begin
          colCount <= '0;
        end else if (shiftEn) begin
          colCount <= colCount + COL_WIDTH'(1);
        end
        if (hsyncRise && (colCount != '0) && (rowCount != '1)) begin
          rowCount <= rowCount + ROW_WIDTH'(1);
        end
        if (overflowHit) begin
          lineOverflowReg <= 1'b1;
        end
      end
    end
  end

  // Line buffers: lb0 holds row y-1, lb1 row y-2; contents need no reset.
  always_ff @(posedge clock) begin
    if (shiftEn) begin
      lineBuf1[lbAddr] <= lb0Rd;
      lineBuf0[lbAddr] <= bus.camData;
    end
  end

  // 3x3 window: row 0 oldest, column 2 newest.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (bus.vsync) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (shiftEn) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1Rd;
      win[1][2] <= lb0Rd;
      win[2][2] <= bus.camData;
    end
  end

  // S1: window valid flag and centre coordinates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1Valid <= 1'b0;
      s1X     <= '0;
      s1Y     <= '0;
    end else begin
      s1Valid <= eligible & ~bus.vsync;
      if (eligible) begin
        s1X <= colCount - COL_WIDTH'(1);
        s1Y <= rowCount - ROW_WIDTH'(1);
      end
    end
  end

  assign gxSum = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
               - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
  assign gySum = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
               - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));

  // S2: register gradients.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2Valid <= 1'b0;
      gxReg   <= '0;
      gyReg   <= '0;
      s2X     <= '0;
      s2Y     <= '0;
    end else begin
      s2Valid <= s1Valid & ~bus.vsync;
      if (s1Valid) begin
        gxReg <= gxSum;
        gyReg <= gySum;
        s2X   <= s1X;
        s2Y   <= s1Y;
      end
    end
  end

  assign magSum = absMag(gxReg) + absMag(gyReg);

`ifdef SOBEL_THRESHOLD_EN
  assign edgeNext = (magSum >= threshold);
`else
  logic unusedThreshold;
  assign unusedThreshold = ^threshold;
  assign edgeNext        = 1'b0;
`endif

  // S3: output registers; result fields hold while no strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixelValidReg <= 1'b0;
      magnitudeReg  <= '0;
      pixelXReg     <= '0;
      pixelYReg     <= '0;
      edgeReg       <= 1'b0;
    end else begin
      pixelValidReg <= s2Valid & ~bus.vsync;
      if (s2Valid && !bus.vsync) begin
        magnitudeReg <= magSum;
        pixelXReg    <= s2X;
        pixelYReg    <= s2Y;
        edgeReg      <= edgeNext;
      end
    end
  end

  assign bus.pixelValid   = pixelValidReg;
  assign bus.magnitude    = magnitudeReg;
  assign bus.pixelX       = pixelXReg;
  assign bus.pixelY       = pixelYReg;
  assign bus.edgeOut      = edgeReg;
  assign bus.lineOverflow = lineOverflowReg;
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter on an 8x8 frame (LINE_WIDTH=8).
module tb_sobel_stream_filter;
  localparam int unsigned PW = 8;
  localparam int unsigned LW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [PW+2:0] threshold;

  always #5 clock = ~clock;

  sobel_stream_filter_if #(.PIXEL_WIDTH(PW), .COL_WIDTH(CW), .ROW_WIDTH(RW)) bus ();

  sobel_stream_filter #(
    .PIXEL_WIDTH(PW), .LINE_WIDTH(LW), .COL_WIDTH(CW), .ROW_WIDTH(RW)
  ) dut (
    .clock(clock), .reset(reset), .threshold(threshold), .bus(bus)
  );

  int testCount = 0;
  int failCount = 0;
  int cycleNo   = 0;
  int img    [8][8];
  int resMag [8][8];
  int resEdge[8][8];
  int strobeCount, badCoord, firstX, firstY, firstCycle, acceptCycle, maxMag;

  task automatic checkValue(input string tag, input int observed, input int expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock; record any result strobe seen just after the edge.
  task automatic tick();
    int px, py, mg;
    @(posedge clock);
    #1;
    cycleNo++;
    if (bus.pixelValid === 1'b1) begin
      px = int'(bus.pixelX);
      py = int'(bus.pixelY);
      mg = int'(bus.magnitude);
      if (strobeCount == 0) begin
        firstX     = px;
        firstY     = py;
        firstCycle = cycleNo;
      end
      strobeCount++;
      if (mg > maxMag) maxMag = mg;
      if (px >= 1 && px <= 6 && py >= 1 && py <= 6) begin
        resMag[py][px]  = mg;
        resEdge[py][px] = int'(bus.edgeOut);
      end else begin
        badCoord++;
      end
    end
  endtask

  task automatic clearResults();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        resMag[y][x]  = -1;
        resEdge[y][x] = -1;
      end
    strobeCount = 0; badCoord = 0; firstX = -1; firstY = -1;
    firstCycle = -1; acceptCycle = -100; maxMag = 0;
  endtask

  // 0 flat 100, 1 vertical edge, 2 horizontal edge, 3 checkerboard.
  task automatic fillImage(input int kind);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (kind)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c >= 4) ? 255 : 0;
          2:       img[r][c] = (r >= 4) ? 255 : 0;
          default: img[r][c] = ((r + c) % 2 == 1) ? 255 : 0;
        endcase
  endtask

  function automatic int expMag(input int kind, input int y, input int x);
    case (kind)
      1:       return (x == 3 || x == 4) ? 1020 : 0;
      2:       return (y == 3 || y == 4) ? 1020 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic sendRow(input int r, input int n, input bit vds);
    bus.hsync = 1'b1; bus.validCamera = vds; bus.camData = 8'd33;
    tick(); tick();
    bus.hsync = 1'b0;
    for (int c = 0; c < n; c++) begin
      bus.validCamera = 1'b1;
      bus.camData     = (c < 8) ? 8'(img[r][c]) : 8'd77;
      if (r == 2 && c == 2) acceptCycle = cycleNo;
      tick();
      if (n > int'(LW) && c == int'(LW) - 1) checkValue("ovfBefore9th", int'(bus.lineOverflow), 0);
      if (n > int'(LW) && c == int'(LW))     checkValue("ovfAfter9th", int'(bus.lineOverflow), 1);
    end
    bus.validCamera = 1'b0;
  endtask

  task automatic startFrame(input bit vds);
    bus.vsync = 1'b1; bus.hsync = 1'b0; bus.validCamera = vds;
    tick(); tick();
    bus.vsync = 1'b0; bus.validCamera = 1'b0;
  endtask

  task automatic endFrame(input bit vds);
    bus.hsync = 1'b1; bus.validCamera = vds;
    repeat (6) tick();
    bus.validCamera = 1'b0;
  endtask

  task automatic sendFrame(input int kind, input bit doVsync, input bit vds, input int overRow);
    clearResults();
    fillImage(kind);
    if (doVsync) startFrame(vds);
    for (int r = 0; r < 8; r++) sendRow(r, (r == overRow) ? 10 : 8, vds);
    endFrame(vds);
  endtask

  task automatic checkFrame(input int kind, input string name);
    int em, ee;
    checkValue({name, "_strobes"}, strobeCount, 36);
    checkValue({name, "_badCoord"}, badCoord, 0);
    for (int y = 1; y <= 6; y++)
      for (int x = 1; x <= 6; x++) begin
        em = expMag(kind, y, x);
`ifdef SOBEL_THRESHOLD_EN
        ee = (em >= 500) ? 1 : 0;
`else
        ee = 0;
`endif
        checkValue($sformatf("%s_mag_y%0d_x%0d", name, y, x), resMag[y][x], em);
        checkValue($sformatf("%s_edge_y%0d_x%0d", name, y, x), resEdge[y][x], ee);
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; threshold = 11'd500;
    bus.hsync = 1'b0; bus.vsync = 1'b0; bus.validCamera = 1'b0; bus.camData = '0;
    clearResults();
    repeat (3) tick();
    checkValue("rstPixelValid", int'(bus.pixelValid), 0);
    checkValue("rstMagnitude", int'(bus.magnitude), 0);
    checkValue("rstPixelX", int'(bus.pixelX), 0);
    checkValue("rstPixelY", int'(bus.pixelY), 0);
    checkValue("rstEdgeOut", int'(bus.edgeOut), 0);
    checkValue("rstOverflow", int'(bus.lineOverflow), 0);
    reset = 1'b1;
    tick();

    // Flat frame: all zero, first result 3 cycles after accept of (2,2).
    sendFrame(0, 1'b1, 1'b0, -1);
    checkFrame(0, "flat");
    checkValue("flatLatency", firstCycle - acceptCycle, 3);
    checkValue("flatFirstX", firstX, 1);
    checkValue("flatFirstY", firstY, 1);

    sendFrame(1, 1'b1, 1'b0, -1);
    checkFrame(1, "vert");
    sendFrame(2, 1'b1, 1'b0, -1);
    checkFrame(2, "horz");
    sendFrame(3, 1'b1, 1'b0, -1);
    checkFrame(3, "checker");
    checkValue("checkerNoWrap", (maxMag <= 2040) ? 1 : 0, 1);

    // Row 3 carries 10 pixels; results must match the plain vertical edge.
    sendFrame(1, 1'b1, 1'b0, 3);
    checkFrame(1, "ovf");
    checkValue("ovfSticky", int'(bus.lineOverflow), 1);
    bus.vsync = 1'b1;
    tick();
    checkValue("ovfClearedByVsync", int'(bus.lineOverflow), 0);
    bus.vsync = 1'b0;

    // vsync right after the completing accept drops that result.
    clearResults();
    fillImage(1);
    startFrame(1'b0);
    sendRow(0, 8, 1'b0);
    sendRow(1, 8, 1'b0);
    sendRow(2, 3, 1'b0);
    bus.vsync = 1'b1;
    repeat (4) tick();
    bus.vsync = 1'b0;
    checkValue("vsyncDrop", strobeCount, 0);
    sendFrame(1, 1'b1, 1'b0, -1);
    checkFrame(1, "afterDrop");
    checkValue("afterDropFirstX", firstX, 1);
    checkValue("afterDropFirstY", firstY, 1);

    // Async reset mid-line after a non-zero result with overflow set.
    clearResults();
    fillImage(1);
    startFrame(1'b0);
    sendRow(0, 8, 1'b0);
    sendRow(1, 10, 1'b0);
    sendRow(2, 8, 1'b0);
    sendRow(3, 8, 1'b0);
    sendRow(4, 6, 1'b0);
    repeat (3) tick();
    checkValue("preRstMagnitude", int'(bus.magnitude), 1020);
    checkValue("preRstPixelX", int'(bus.pixelX), 4);
    checkValue("preRstPixelY", int'(bus.pixelY), 3);
    checkValue("preRstHoldValid", int'(bus.pixelValid), 0);
    checkValue("preRstOverflow", int'(bus.lineOverflow), 1);
    #3 reset = 1'b0;
    #1;
    checkValue("midRstMagnitude", int'(bus.magnitude), 0);
    checkValue("midRstPixelX", int'(bus.pixelX), 0);
    checkValue("midRstPixelY", int'(bus.pixelY), 0);
    checkValue("midRstOverflow", int'(bus.lineOverflow), 0);
    checkValue("midRstEdgeOut", int'(bus.edgeOut), 0);
    checkValue("midRstValid", int'(bus.pixelValid), 0);
    #2 reset = 1'b1;
    // Fresh rows with validCamera held high through every hsync gap.
    sendFrame(1, 1'b0, 1'b1, -1);
    checkFrame(1, "postRst");
    checkValue("postRstFirstX", firstX, 1);
    checkValue("postRstFirstY", firstY, 1);
    checkValue("postRstLatency", firstCycle - acceptCycle, 3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
